// File: rtl/riscv_test_monitor_pkg.sv
// riscv_test_pkg: shared status/state encodings and default magic words for the test monitor
package riscv_test_pkg;

    typedef enum logic [1:0] {ST_NONE, ST_PASS, ST_FAIL, ST_UNKNOWN} tst_status_e;

    typedef enum logic [1:0] {TM_IDLE, TM_RUN, TM_HALTED, TM_TIMEOUT} tm_state_e;

    localparam logic [31:0] HALT_INST_C  = 32'hdead10cc;
    localparam logic [31:0] PASS_MAGIC_C = 32'h00c0ffee;
    localparam logic [31:0] FAIL_MAGIC_C = 32'hdeaddead;

endpackage

// File: rtl/riscv_test_monitor_ch.sv
// riscv_test_monitor_ch: per-hart end-of-test FSM, a0 classifier and cycle latch
module riscv_test_monitor_ch
    import riscv_test_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] MAX_CNT    = CNT_W'(10000),
    parameter logic [XLEN-1:0]  HALT_INST  = XLEN'(HALT_INST_C),
    parameter logic [XLEN-1:0]  PASS_MAGIC = XLEN'(PASS_MAGIC_C),
    parameter logic [XLEN-1:0]  FAIL_MAGIC = XLEN'(FAIL_MAGIC_C)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inst_vld,
    input  logic [XLEN-1:0]  inst,
    input  logic [XLEN-1:0]  a0,
    input  logic [CNT_W-1:0] cnt,
    output logic             run,
    output logic             done,
    output logic [1:0]       status,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    tm_state_e   state;
    tst_status_e st;
    tst_status_e cls;
    logic        halt;

    assign run    = state == TM_RUN;
    assign halt   = run && inst_vld && inst == HALT_INST;
    assign cls    = a0 == PASS_MAGIC ? ST_PASS : a0 == FAIL_MAGIC ? ST_FAIL : ST_UNKNOWN;
    assign status = st;

    // start outranks a coincident halt; halt outranks a coincident timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TM_IDLE;
            done    <= 1'b0;
            st      <= ST_NONE;
            timeout <= 1'b0;
            cycles  <= '0;
        end else if (start) begin
            state   <= TM_RUN;
            done    <= 1'b0;
            st      <= ST_NONE;
            timeout <= 1'b0;
            cycles  <= '0;
        end else if (halt) begin
            state   <= TM_HALTED;
            done    <= 1'b1;
            st      <= cls;
            cycles  <= cnt;
        end else if (run && cnt == MAX_CNT) begin
            state   <= TM_TIMEOUT;
            done    <= 1'b1;
            timeout <= 1'b1;
            cycles  <= MAX_CNT;
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: multi-hart riscv-tests end-of-test monitor with shared saturating cycle counter
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int              NUM_CH     = 1,
    parameter int              XLEN       = 32,
    parameter int              CNT_W      = 32,
    parameter int              MAX_CYCLES = 10000,
    parameter logic [XLEN-1:0] HALT_INST  = XLEN'(HALT_INST_C),
    parameter logic [XLEN-1:0] PASS_MAGIC = XLEN'(PASS_MAGIC_C),
    parameter logic [XLEN-1:0] FAIL_MAGIC = XLEN'(FAIL_MAGIC_C)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [NUM_CH-1:0]       inst_vld_i,
    input  logic [NUM_CH*XLEN-1:0]  inst_i,
    input  logic [NUM_CH*XLEN-1:0]  a0_i,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH*2-1:0]     status_o,
    output logic [NUM_CH-1:0]       timeout_o,
    output logic [NUM_CH*CNT_W-1:0] cycles_o,
    output logic                    all_done_o,
    output logic                    all_pass_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] pass;

    // counts only while some hart is still running and sticks at the timeout value
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (start_i)
            cnt <= '0;
        else if (|run && cnt != MAX_C)
            cnt <= cnt + CNT_W'(1);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        riscv_test_monitor_ch #(
            .XLEN       (XLEN),
            .CNT_W      (CNT_W),
            .MAX_CNT    (MAX_C),
            .HALT_INST  (HALT_INST),
            .PASS_MAGIC (PASS_MAGIC),
            .FAIL_MAGIC (FAIL_MAGIC)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .start    (start_i),
            .inst_vld (inst_vld_i[i]),
            .inst     (inst_i[i*XLEN +: XLEN]),
            .a0       (a0_i[i*XLEN +: XLEN]),
            .cnt      (cnt),
            .run      (run[i]),
            .done     (done_o[i]),
            .status   (status_o[i*2 +: 2]),
            .timeout  (timeout_o[i]),
            .cycles   (cycles_o[i*CNT_W +: CNT_W])
        );
        assign pass[i] = status_o[i*2 +: 2] == ST_PASS;
    end

    assign all_done_o = &done_o;
    assign all_pass_o = all_done_o && &pass;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: randomized scoreboard bench for the multi-hart test monitor
module tb_riscv_test_monitor;

    localparam int N    = 4;
    localparam int MAXC = 50;
    localparam logic [31:0] HALT  = 32'hdead10cc;
    localparam logic [31:0] PASSM = 32'h00c0ffee;
    localparam logic [31:0] FAILM = 32'hdeaddead;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  vld = '0;
    logic [N*32-1:0] inst = '0;
    logic [N*32-1:0] a0 = '0;
    logic [N-1:0]  done_o;
    logic [N*2-1:0] status_o;
    logic [N-1:0]  timeout_o;
    logic [N*32-1:0] cycles_o;
    logic          all_done_o;
    logic          all_pass_o;

    riscv_test_monitor #(.NUM_CH(N), .XLEN(32), .CNT_W(32), .MAX_CYCLES(MAXC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .inst_vld_i (vld),
        .inst_i     (inst),
        .a0_i       (a0),
        .done_o     (done_o),
        .status_o   (status_o),
        .timeout_o  (timeout_o),
        .cycles_o   (cycles_o),
        .all_done_o (all_done_o),
        .all_pass_o (all_pass_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [1:0]  st;
        logic        to;
        logic [31:0] cyc;
    } res_t;

    res_t        exp_q[$];
    res_t        last[N];
    logic [N-1:0] have_last = '0;
    logic [N-1:0] prev_done = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          h_at[N];
    logic [31:0] a0v[N];

    function automatic logic [1:0] cls(input logic [31:0] v);
        return v == PASSM ? 2'b01 : v == FAILM ? 2'b10 : 2'b11;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_done"}, 64'(done_o), 0);
        chk({tag, "_status"}, 64'(status_o), 0);
        chk({tag, "_timeout"}, 64'(timeout_o), 0);
        chk({tag, "_cycles"}, 64'(cycles_o), 0);
        chk({tag, "_all_done"}, 64'(all_done_o), 0);
        chk({tag, "_all_pass"}, 64'(all_pass_o), 0);
    endtask

    // monitor: a rising done pops that channel's expected result; a held done must keep it
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (done_o[i] && !prev_done[i]) begin
                    idx = -1;
                    foreach (exp_q[j]) if (idx < 0 && exp_q[j].ch == i) idx = j;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_done_ch%0d", i), 1, 0);
                        have_last[i] = 1'b0;
                    end else begin
                        last[i] = exp_q[idx];
                        have_last[i] = 1'b1;
                        exp_q.delete(idx);
                    end
                end
                if (done_o[i] && have_last[i]) begin
                    chk($sformatf("status_ch%0d", i), 64'(status_o[2*i +: 2]), 64'(last[i].st));
                    chk($sformatf("timeout_ch%0d", i), 64'(timeout_o[i]), 64'(last[i].to));
                    chk($sformatf("cycles_ch%0d", i), 64'(cycles_o[32*i +: 32]), 64'(last[i].cyc));
                end
            end
            prev_done = done_o;
        end
    end

    // kind 0 aborts with a start pulse, kind 1 with an async reset pulse
    task automatic run(input int abort_at, input int kind, input bit no_start);
        logic [N-1:0] fin = '0;
        logic [N-1:0] ps = '0;
        logic [31:0]  r;
        res_t         e;
        if (!no_start) begin
            start = 1'b1;
            vld = '0;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int k = 0; k <= MAXC + 3; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k == h_at[i]) begin
                    vld[i] = 1'b1;
                    inst[32*i +: 32] = HALT;
                    a0[32*i +: 32] = a0v[i];
                    if (!fin[i] && k <= MAXC && k != abort_at) begin
                        e = '{i, cls(a0v[i]), 1'b0, 32'(k)};
                        exp_q.push_back(e);
                        fin[i] = 1'b1;
                        ps[i] = cls(a0v[i]) == 2'b01;
                    end
                end else if (h_at[i] >= 0 && k > h_at[i] && $urandom_range(1) == 1) begin
                    vld[i] = 1'b1;
                    inst[32*i +: 32] = HALT;
                    a0[32*i +: 32] = $urandom;
                end else begin
                    r = $urandom;
                    if (r == HALT) r = 32'h13;
                    vld[i] = 1'($urandom_range(1));
                    if ($urandom_range(3) == 0) begin
                        inst[32*i +: 32] = HALT;
                        vld[i] = 1'b0;
                    end else begin
                        inst[32*i +: 32] = r;
                    end
                    a0[32*i +: 32] = $urandom_range(1) == 1 ? PASSM : $urandom;
                end
                if (k == MAXC && !fin[i] && k != abort_at) begin
                    e = '{i, 2'b00, 1'b1, 32'(MAXC)};
                    exp_q.push_back(e);
                    fin[i] = 1'b1;
                end
            end
            if (k == abort_at) begin
                if (kind == 0) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                    vld = '0;
                    @(negedge clk);
                    chk_clear("restart");
                end else begin
                    #3 rst = 1'b1;
                    #1 chk_clear("async_rst");
                    exp_q.delete();
                    @(posedge clk);
                    #1 rst = 1'b0;
                    vld = '0;
                end
                return;
            end
            @(posedge clk);
            #1;
            chk("all_done", 64'(all_done_o), 64'(&fin));
            chk("all_pass", 64'(all_pass_o), 64'(&fin && &ps));
        end
        vld = '0;
        @(negedge clk);
        chk("pending_results", 64'(exp_q.size()), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_clear("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_clear("after_reset");

        h_at = '{37, 5, 12, 20};
        a0v  = '{PASSM, PASSM, PASSM, PASSM};
        run(-1, 0, 0);

        h_at = '{8, 9, 10, 11};
        a0v  = '{FAILM, PASSM, 32'h1234, PASSM};
        run(-1, 0, 0);

        h_at = '{50, -1, -1, 60};
        a0v  = '{PASSM, PASSM, PASSM, PASSM};
        run(-1, 0, 0);

        h_at = '{10, 20, 30, 40};
        run(-1, 0, 0);

        h_at = '{5, 25, 30, -1};
        run(25, 0, 0);
        h_at = '{7, 14, 21, 28};
        run(-1, 0, 1);

        h_at = '{3, 4, -1, -1};
        run(15, 1, 0);

        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++) begin
                h_at[i] = $urandom_range(5) == 0 ? -1 : int'($urandom_range(MAXC + 8));
                case ($urandom_range(2))
                    0: a0v[i] = PASSM;
                    1: a0v[i] = FAILM;
                    default: a0v[i] = $urandom;
                endcase
            end
            run(-1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
